// File: rtl/dsp_mac_sequencer_if.sv
// Signal bundle between the dot-product sequencer, its job/stream/result
// client and the DSP48A1 slice it drives.
interface dsp_mac_sequencer_if #(
    parameter int LEN_W = 10
);
    // Job request
    logic             start;
    logic [LEN_W-1:0] len;
    logic             sub;
    logic             busy;

    // Operand stream
    logic             in_valid;
    logic             in_ready;
    logic [17:0]      in_a;
    logic [17:0]      in_b;

    // Result
    logic             res_valid;
    logic             res_ready;
    logic [47:0]      res_p;

    // Slice pins
    logic [17:0]      dsp_a;
    logic [17:0]      dsp_b;
    logic [7:0]       dsp_opmode;
    logic             dsp_ce;
    logic             dsp_cep;
    logic             dsp_rstp;
    logic             dsp_rst_all;
    logic [47:0]      dsp_p;

    // Client plus slice side: issues jobs and operands, returns the slice P.
    modport master (
        output start, len, sub, in_valid, in_a, in_b, res_ready, dsp_p,
        input  busy, in_ready, res_valid, res_p,
        input  dsp_a, dsp_b, dsp_opmode, dsp_ce, dsp_cep, dsp_rstp, dsp_rst_all
    );

    // Sequencer side.
    modport slave (
        input  start, len, sub, in_valid, in_a, in_b, res_ready, dsp_p,
        output busy, in_ready, res_valid, res_p,
        output dsp_a, dsp_b, dsp_opmode, dsp_ce, dsp_cep, dsp_rstp, dsp_rst_all
    );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP48A1 slice (A1REG/B1REG/MREG/PREG/OPMODEREG = 1) as an
// unsigned 18x18 dot-product engine with a 48-bit accumulator in P.
module dsp_mac_sequencer #(
    parameter int LEN_W    = 10,
    parameter int PIPE_LAT = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    dsp_mac_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_e;

    // X = M, Z = P, pre-adder bypassed, CIN = 0; bit 7 selects Z - X.
    localparam logic [7:0]       OPM_ADD = 8'h09;
    localparam logic [7:0]       OPM_SUB = 8'h89;
    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                sub_q, sub_d;
    logic [PIPE_LAT-1:0] vpipe_q, vpipe_d;

    logic                room;
    logic                accept;
    logic                pipe_empty_d;
    logic                all_taken_d;
    logic [7:0]          job_opmode;

    assign room         = (cnt_q < len_q);
    assign accept       = (state_q == S_LOAD) && room && bus.in_valid;
    // Bit i set means the pair accepted i+1 cycles ago is in the slice pipe;
    // the top bit lines up with that product sitting in MREG.
    assign vpipe_d      = {vpipe_q[PIPE_LAT-2:0], accept};
    assign pipe_empty_d = (vpipe_d == '0);
    assign all_taken_d  = (cnt_d == len_q);
    assign job_opmode   = sub_q ? OPM_SUB : OPM_ADD;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q   <= '0;
            len_q   <= '0;
            sub_q   <= 1'b0;
            vpipe_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sub_q   <= sub_d;
            vpipe_q <= vpipe_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        len_d = len_q;
        sub_d = sub_q;
        if ((state_q == S_IDLE) && bus.start) begin
            len_d = bus.len;
            sub_d = bus.sub;
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_CLR;
            S_CLR:   state_d = S_LOAD;
            S_LOAD: begin
                // An empty job has nothing in flight and finishes straight away.
                if (all_taken_d) state_d = pipe_empty_d ? S_DONE : S_DRAIN;
            end
            // Leave once the final CEP cycle is the current one.
            S_DRAIN: if (pipe_empty_d) state_d = S_DONE;
            S_DONE:  if (bus.res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = 1'b0;
        bus.in_ready   = 1'b0;
        bus.res_valid  = 1'b0;
        bus.dsp_ce     = 1'b0;
        bus.dsp_cep    = 1'b0;
        bus.dsp_rstp   = 1'b0;
        bus.dsp_opmode = 8'h00;
        bus.dsp_a      = '0;
        bus.dsp_b      = '0;
        if (!RST_N) begin
            bus.dsp_rstp = 1'b1;
        end else begin
            case (state_q)
                S_CLR: begin
                    bus.busy       = 1'b1;
                    bus.dsp_rstp   = 1'b1;
                    bus.dsp_ce     = 1'b1;
                    bus.dsp_opmode = job_opmode;
                end
                S_LOAD: begin
                    bus.busy       = 1'b1;
                    bus.dsp_ce     = 1'b1;
                    bus.dsp_cep    = vpipe_q[PIPE_LAT-1];
                    bus.dsp_opmode = job_opmode;
                    bus.in_ready   = room;
                    bus.dsp_a      = bus.in_a;
                    bus.dsp_b      = bus.in_b;
                end
                S_DRAIN: begin
                    bus.busy       = 1'b1;
                    bus.dsp_ce     = 1'b1;
                    bus.dsp_cep    = vpipe_q[PIPE_LAT-1];
                    bus.dsp_opmode = job_opmode;
                end
                S_DONE: begin
                    bus.busy       = 1'b1;
                    bus.res_valid  = 1'b1;
                    bus.dsp_opmode = job_opmode;
                end
                default: ;
            endcase
        end
    end

    // The slice's own input/pipeline registers follow the sequencer reset.
    assign bus.dsp_rst_all = ~RST_N;
    assign bus.res_p       = bus.dsp_p;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: behavioural DSP48A1 slice, a job-level
// reference model compared every cycle, and directed jobs with literal results.
module tb_dsp_mac_sequencer;

    localparam int LEN_W = 10;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    dsp_mac_sequencer_if #(.LEN_W(LEN_W)) bus ();

    dsp_mac_sequencer #(
        .LEN_W   (LEN_W),
        .PIPE_LAT(2)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
        end
    endtask

    // ---------------- DSP48A1 slice model ----------------
    logic [17:0] a1_r, b1_r;
    logic [35:0] m_r;
    logic [7:0]  opm_r;
    logic [47:0] p_r;
    logic [47:0] x_mux, z_mux, post;

    always_comb begin
        x_mux = (opm_r[1:0] == 2'b01) ? {12'b0, m_r} : 48'b0;
        z_mux = (opm_r[3:2] == 2'b10) ? p_r : 48'b0;
        post  = opm_r[7] ? (z_mux - x_mux) : (z_mux + x_mux);
    end

    always @(posedge CLK) begin
        if (bus.dsp_rst_all) begin
            a1_r  <= '0;
            b1_r  <= '0;
            m_r   <= '0;
            opm_r <= '0;
        end else if (bus.dsp_ce) begin
            a1_r  <= bus.dsp_a;
            b1_r  <= bus.dsp_b;
            m_r   <= 36'(a1_r) * 36'(b1_r);
            opm_r <= bus.dsp_opmode;
        end
        if (bus.dsp_rstp)     p_r <= '0;
        else if (bus.dsp_cep) p_r <= post;
    end

    assign bus.dsp_p = p_r;

    // ---------------- job-level reference model and per-cycle compare ----------------
    bit          job_m;
    longint      clr_m, last_acc_m, done_t;
    int          n_m, acc_m;
    logic [47:0] sum_m;
    bit          sub_m;
    logic [7:0]  opm_m;
    longint      acc_q[$];
    bit          exp_ready, exp_rv, exp_cep;

    initial begin
        job_m = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                check("rst_busy", bus.busy, 0);
                check("rst_in_ready", bus.in_ready, 0);
                check("rst_res_valid", bus.res_valid, 0);
                check("rst_ce", bus.dsp_ce, 0);
                check("rst_cep", bus.dsp_cep, 0);
                check("rst_rstp", bus.dsp_rstp, 1);
                check("rst_rst_all", bus.dsp_rst_all, 1);
                check("rst_opmode", bus.dsp_opmode, 0);
                check("rst_dsp_a", bus.dsp_a, 0);
                check("rst_dsp_b", bus.dsp_b, 0);
                job_m = 1'b0;
                acc_q.delete();
            end else begin
                check("rst_all_low", bus.dsp_rst_all, 0);
                if (!job_m) begin
                    check("idle_busy", bus.busy, 0);
                    check("idle_in_ready", bus.in_ready, 0);
                    check("idle_res_valid", bus.res_valid, 0);
                    check("idle_ce", bus.dsp_ce, 0);
                    check("idle_cep", bus.dsp_cep, 0);
                    check("idle_opmode", bus.dsp_opmode, 0);
                    if (bus.start) begin
                        job_m = 1'b1;
                        clr_m = cyc + 1;
                        n_m   = int'(bus.len);
                        sub_m = bus.sub;
                        opm_m = bus.sub ? 8'h89 : 8'h09;
                        acc_m = 0;
                        sum_m = '0;
                        acc_q.delete();
                    end
                end else begin
                    check("job_busy", bus.busy, 1);
                    check("job_opmode", bus.dsp_opmode, opm_m);
                    if (cyc == clr_m) begin
                        check("clr_rstp", bus.dsp_rstp, 1);
                        check("clr_ce", bus.dsp_ce, 1);
                        check("clr_in_ready", bus.in_ready, 0);
                        check("clr_res_valid", bus.res_valid, 0);
                        check("clr_cep", bus.dsp_cep, 0);
                    end else begin
                        exp_ready = (acc_m < n_m);
                        exp_cep   = 1'b0;
                        foreach (acc_q[i]) if (acc_q[i] == cyc - 2) exp_cep = 1'b1;
                        if (n_m == 0)          done_t = clr_m + 2;
                        else if (acc_m == n_m) done_t = last_acc_m + 3;
                        else                   done_t = 64'sh7FFF_FFFF_FFFF_FFFF;
                        exp_rv = (cyc >= done_t);
                        check("job_rstp", bus.dsp_rstp, 0);
                        check("in_ready", bus.in_ready, exp_ready);
                        check("cep", bus.dsp_cep, exp_cep);
                        check("res_valid", bus.res_valid, exp_rv);
                        if (!exp_rv) check("job_ce", bus.dsp_ce, 1);
                        if (exp_ready) begin
                            check("dsp_a", bus.dsp_a, bus.in_a);
                            check("dsp_b", bus.dsp_b, bus.in_b);
                        end
                        if (exp_rv) begin
                            check("res_p", bus.res_p, sum_m);
                            if (bus.res_ready) job_m = 1'b0;
                        end
                        if (exp_ready && bus.in_valid) begin
                            acc_m++;
                            last_acc_m = cyc;
                            acc_q.push_back(cyc);
                            if (sub_m) sum_m = sum_m - 48'(bus.in_a) * 48'(bus.in_b);
                            else       sum_m = sum_m + 48'(bus.in_a) * 48'(bus.in_b);
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers (entered/left at posedge+1) ----------------
    task automatic start_job(input int n, input bit s_bit, output longint clr_cyc);
        bus.start = 1'b1;
        bus.len   = LEN_W'(n);
        bus.sub   = s_bit;
        clr_cyc   = cyc + 1;
        @(posedge CLK); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_pair(input logic [17:0] a, input logic [17:0] b, output longint acc_cyc);
        acc_cyc      = -1;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (bus.in_ready) begin
                acc_cyc = cyc;
                break;
            end
            @(posedge CLK); #1;
        end
        @(posedge CLK); #1;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        if (acc_cyc < 0) check("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic wait_result(output longint rv_cyc, output logic [47:0] p);
        rv_cyc = -1;
        p      = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (bus.res_valid) begin
                rv_cyc = cyc;
                p      = bus.res_p;
                break;
            end
        end
        if (rv_cyc < 0) check("result_timeout", 0, 1);
    endtask

    task automatic finish_result(input int hold, input logic [47:0] p0);
        repeat (hold) begin
            @(posedge CLK); #1;
            bus.start = 1'b1;
            bus.len   = LEN_W'(5);
            @(negedge CLK);
            check("hold_valid", bus.res_valid, 1);
            check("hold_p", bus.res_p, p0);
        end
        @(posedge CLK); #1;
        bus.start     = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge CLK); #1;
        bus.res_ready = 1'b0;
        @(negedge CLK);
        check("idle_after_take", bus.busy, 0);
        check("valid_dropped", bus.res_valid, 0);
        @(posedge CLK); #1;
    endtask

    // ---------------- directed jobs ----------------
    longint      s, a0, a1, a2, rv;
    logic [47:0] p;

    initial begin
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.sub       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b0;
        RST_N         = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        check("post_reset_busy", bus.busy, 0);
        check("post_reset_opmode", bus.dsp_opmode, 0);
        @(posedge CLK); #1;

        // Job 1: 2*3 + 4*5 + 6*7 = 68, back-to-back operands.
        start_job(3, 0, s);
        send_pair(18'd2, 18'd3, a0);
        send_pair(18'd4, 18'd5, a1);
        send_pair(18'd6, 18'd7, a2);
        check("t1_first_accept", a0 - s, 1);
        check("t1_last_accept", a2 - s, 3);
        wait_result(rv, p);
        check("t1_latency", rv - s, 6);
        check("t1_result", p, 48'd68);
        finish_result(0, p);

        // Job 2: same pairs with a 2-cycle bubble after the first.
        start_job(3, 0, s);
        send_pair(18'd2, 18'd3, a0);
        idle(2);
        send_pair(18'd4, 18'd5, a1);
        send_pair(18'd6, 18'd7, a2);
        check("t2_last_accept", a2 - s, 5);
        wait_result(rv, p);
        check("t2_latency", rv - s, 8);
        check("t2_result", p, 48'd68);
        finish_result(0, p);

        // Job 3: subtract, -(1 + 4).
        start_job(2, 1, s);
        send_pair(18'd1, 18'd1, a0);
        send_pair(18'd2, 18'd2, a1);
        wait_result(rv, p);
        check("t3_latency", rv - s, 5);
        check("t3_result", p, 48'hFFFF_FFFF_FFFB);
        finish_result(0, p);

        // Job 4: empty job.
        start_job(0, 0, s);
        wait_result(rv, p);
        check("t4_latency", rv - s, 2);
        check("t4_result", p, 48'd0);
        finish_result(0, p);

        // Job 5: four maximal products, then a held result with start ignored.
        start_job(4, 0, s);
        for (int i = 0; i < 4; i++) send_pair(18'h3FFFF, 18'h3FFFF, a0);
        check("t5_last_accept", a0 - s, 4);
        wait_result(rv, p);
        check("t5_latency", rv - s, 7);
        check("t5_result", p, 48'h003F_FFE0_0004);
        finish_result(5, p);

        // Job 6: reset after the second accept abandons the job.
        start_job(4, 0, s);
        send_pair(18'd7, 18'd9, a0);
        send_pair(18'd11, 18'd13, a1);
        RST_N = 1'b0;
        @(negedge CLK);
        check("abort_rst_all", bus.dsp_rst_all, 1);
        check("abort_busy", bus.busy, 0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        repeat (10) begin
            @(negedge CLK);
            check("abort_no_result", bus.res_valid, 0);
            check("abort_idle", bus.busy, 0);
        end
        @(posedge CLK); #1;

        // Job 7: fresh job after the abort.
        start_job(1, 0, s);
        send_pair(18'd3, 18'd3, a0);
        wait_result(rv, p);
        check("t7_latency", rv - s, 4);
        check("t7_result", p, 48'd9);
        finish_result(0, p);

        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

endmodule
